// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared definitions for the multi-byte add sequencer: state encoding,
// byte width and the index-width helper.
package multibyte_add_sequencer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte index width: clog2 of the byte count, never narrower than one bit.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Bus bundle between the sequencer, its requester and the external 8-bit adder.
interface multibyte_add_sequencer_if
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
);

  logic                       start;
  logic                       op_sub;
  logic                       cin;
  logic [BYTE_W*NBYTES-1:0]   a_in;
  logic [BYTE_W*NBYTES-1:0]   b_in;
  logic [BYTE_W-1:0]          add_x;
  logic [BYTE_W-1:0]          add_y;
  logic                       add_c0;
  logic [BYTE_W-1:0]          add_s;
  logic                       add_c8;
  logic                       busy;
  logic                       done;
  logic [BYTE_W*NBYTES-1:0]   sum;
  logic                       cout;
  logic                       ovf;

  // Requester plus adder side.
  modport master (
    output start, op_sub, cin, a_in, b_in, add_s, add_c8,
    input  add_x, add_y, add_c0, busy, done, sum, cout, ovf
  );

  // Sequencer side.
  modport slave (
    input  start, op_sub, cin, a_in, b_in, add_s, add_c8,
    output add_x, add_y, add_c0, busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/multibyte_add_sequencer_byte_select.sv
// Combinational byte-lane mux: picks byte idx_i out of both latched operands.
module mas_byte_select
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IDX_W  = 2
) (
  input  logic [BYTE_W*NBYTES-1:0] a_i,
  input  logic [BYTE_W*NBYTES-1:0] b_i,
  input  logic [IDX_W-1:0]         idx_i,
  output logic [BYTE_W-1:0]        a_byte_o,
  output logic [BYTE_W-1:0]        b_byte_o
);

  // Select the current byte lane of each operand.
  always_comb begin
    a_byte_o = a_i[int'(idx_i) * BYTE_W +: BYTE_W];
    b_byte_o = b_i[int'(idx_i) * BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial front/back-end for an external 8-bit adder: feeds operands LSB
// byte first, chains carries and assembles the wide sum, carry-out and overflow.
module multibyte_add_sequencer
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic                      clk,
  input logic                      rst,
  multibyte_add_sequencer_if.slave bus
);

  localparam int              W        = BYTE_W * NBYTES;
  localparam int              IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic [BYTE_W-1:0]  a_byte_s;
  logic [BYTE_W-1:0]  b_byte_s;
  logic               last_s;

  mas_byte_select #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_byte_select (
    .a_i      (a_q),
    .b_i      (b_q),
    .idx_i    (idx_q),
    .a_byte_o (a_byte_s),
    .b_byte_o (b_byte_s)
  );

  assign last_s = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NBYTES cycles, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
        else           state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on start; per-byte sum capture and carry chaining during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            // Subtraction is A + ~B + 1; the +1 enters through the first carry.
            b_q     <= bus.op_sub ? ~bus.b_in : bus.b_in;
            carry_q <= bus.op_sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[int'(idx_q) * BYTE_W +: BYTE_W] <= bus.add_s;
          carry_q <= bus.add_c8;
          if (last_s) begin
            cout_q <= bus.add_c8;
            // Overflow: operands share a sign that the result does not.
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (bus.add_s[BYTE_W-1] != a_q[W-1]);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Adder drive: current byte lanes and chained carry in RUN, quiet otherwise.
  always_comb begin
    bus.add_x  = 8'd0;
    bus.add_y  = 8'd0;
    bus.add_c0 = 1'b0;
    if (state_q == RUN) begin
      bus.add_x  = a_byte_s;
      bus.add_y  = b_byte_s;
      bus.add_c0 = carry_q;
    end else begin
      bus.add_x  = 8'd0;
      bus.add_y  = 8'd0;
      bus.add_c0 = 1'b0;
    end
  end

  assign bus.busy = (state_q == RUN) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer with a behavioural 8-bit adder
// beside each instance (NBYTES=4 and NBYTES=1).
module tb_multibyte_add_sequencer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  multibyte_add_sequencer_if #(.NBYTES(4)) b4 ();
  multibyte_add_sequencer_if #(.NBYTES(1)) b1 ();

  multibyte_add_sequencer #(.NBYTES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  multibyte_add_sequencer #(.NBYTES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Reference 8-bit adders standing in for hybridadder8_struct.
  assign {b4.add_c8, b4.add_s} = {1'b0, b4.add_x} + {1'b0, b4.add_y} + {8'd0, b4.add_c0};
  assign {b1.add_c8, b1.add_s} = {1'b0, b1.add_x} + {1'b0, b1.add_y} + {8'd0, b1.add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Run one NBYTES=4 operation and check result, latency and pulse width.
  task automatic run4(input string name, input logic sub, input logic c,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_sum, input logic exp_cout,
                      input logic exp_ovf, input logic inject,
                      output logic [3:0] c0_seq);
    int lat;
    @(negedge clk);
    b4.start = 1'b1; b4.op_sub = sub; b4.cin = c; b4.a_in = a; b4.b_in = b;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.op_sub = ~sub; b4.cin = ~c; b4.a_in = ~a; b4.b_in = ~b;
    lat = 0;
    c0_seq = 4'd0;
    while (b4.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      if (lat < 4) c0_seq[lat] = b4.add_c0;
      if (inject && lat == 1) begin
        b4.start = 1'b1; b4.op_sub = 1'b1; b4.a_in = 32'h12345678; b4.b_in = 32'h0F0F0F0F;
      end
      @(posedge clk); #1;
      b4.start = 1'b0;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    check({name, "_sum"}, {32'd0, b4.sum}, {32'd0, exp_sum});
    check({name, "_cout_ovf"}, {62'd0, b4.cout, b4.ovf}, {62'd0, exp_cout, exp_ovf});
    @(posedge clk); #1;
    check({name, "_pulse_end"}, {62'd0, b4.done, b4.busy}, 64'd0);
  endtask

  initial begin
    logic [3:0] c0s;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    b4.start = 1'b0; b4.op_sub = 1'b0; b4.cin = 1'b0; b4.a_in = 32'd0; b4.b_in = 32'd0;
    b1.start = 1'b0; b1.op_sub = 1'b0; b1.cin = 1'b0; b1.a_in = 8'd0;  b1.b_in = 8'd0;

    #12;
    check("reset_status", {60'd0, b4.busy, b4.done, b4.cout, b4.ovf}, 64'd0);
    check("reset_sum", {32'd0, b4.sum}, 64'd0);
    check("reset_adder_drive", {47'd0, b4.add_x, b4.add_y, b4.add_c0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run4("add_ff_1", 1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, c0s);
    run4("add_wrap", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, c0s);
    check("add_wrap_c0_seq", {60'd0, c0s}, 64'hE);
    run4("sub_5_7", 1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, c0s);
    run4("sub_7_5", 1'b1, 1'b0, 32'd7, 32'd5, 32'h00000002, 1'b1, 1'b0, 1'b0, c0s);
    run4("add_ovf", 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, c0s);
    run4("busy_start", 1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b1, c0s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_start_no_requeue", {63'd0, b4.busy}, 64'd0);
    run4("sub_ovf", 1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, c0s);

    // Asynchronous reset in the third RUN cycle.
    @(negedge clk);
    b4.start = 1'b1; b4.op_sub = 1'b0; b4.cin = 1'b0;
    b4.a_in = 32'h11223344; b4.b_in = 32'h01010101;
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_status", {60'd0, b4.busy, b4.done, b4.cout, b4.ovf}, 64'd0);
    check("abort_sum", {32'd0, b4.sum}, 64'd0);
    check("abort_adder_drive", {47'd0, b4.add_x, b4.add_y, b4.add_c0}, 64'd0);
    @(posedge clk); #1;
    check("abort_no_done", {63'd0, b4.done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run4("after_abort", 1'b0, 1'b0, 32'h11223344, 32'h01010101, 32'h12233445, 1'b0, 1'b0, 1'b0, c0s);

    // Single-byte instance: RUN lasts one cycle.
    @(negedge clk);
    b1.start = 1'b1; b1.op_sub = 1'b0; b1.cin = 1'b0; b1.a_in = 8'hFF; b1.b_in = 8'h01;
    @(posedge clk); #1;
    b1.start = 1'b0;
    check("nb1_run_state", {62'd0, b1.busy, b1.done}, 64'd2);
    @(posedge clk); #1;
    check("nb1_done", {63'd0, b1.done}, 64'd1);
    check("nb1_sum", {56'd0, b1.sum}, 64'd0);
    check("nb1_cout_ovf", {62'd0, b1.cout, b1.ovf}, 64'd2);
    @(posedge clk); #1;
    check("nb1_pulse_end", {62'd0, b1.done, b1.busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
